// File: rtl/bitserial_mac_lanes_if.sv
// bitserial_mac_lanes_if: operand/result handshake bundle for bitserial_mac_lanes
interface bitserial_mac_lanes_if #(
  parameter int LANES = 4,
  parameter int ACT_W = 8,
  parameter int WGT_W = 8,
  parameter int ACC_W = 20
);
  logic [1:0]                 prec;
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_last;
  logic                       acc_clr;
  logic [LANES*ACT_W-1:0]     act;
  logic [LANES*WGT_W-1:0]     wgt;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*ACC_W-1:0]     out_acc;
  logic [$clog2(WGT_W)-1:0]   bit_cnt;
  logic [LANES-1:0]           ovf;
  modport master (
    output prec, in_valid, in_last, acc_clr, act, wgt, out_ready,
    input  in_ready, out_valid, out_acc, bit_cnt, ovf
  );
  modport slave (
    input  prec, in_valid, in_last, acc_clr, act, wgt, out_ready,
    output in_ready, out_valid, out_acc, bit_cnt, ovf
  );
endinterface

// File: rtl/bitserial_mac_lanes.sv
// bitserial_mac_lanes: lockstep bit-serial signed MAC lanes, LSB-first weights, selectable precision.
// Define BITSERIAL_SAT_EN for saturating accumulators with sticky per-lane ovf; otherwise they wrap.
module bitserial_mac_lanes #(
  parameter int LANES = 4,
  parameter int ACT_W = 8,
  parameter int WGT_W = 8,
  parameter int ACC_W = 20
) (
  input logic clk,
  input logic rst,
  bitserial_mac_lanes_if.slave bus
);
  localparam int PW = ACT_W + WGT_W;
  localparam int BW = $clog2(WGT_W);
  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
  state_t                  r_state;
  logic signed [ACT_W-1:0] r_act [LANES];
  logic [WGT_W-1:0]        r_wgt [LANES];
  logic signed [PW-1:0]    r_p   [LANES];
  logic signed [ACC_W-1:0] r_acc [LANES];
  logic [LANES-1:0]        r_ovf;
  logic                    r_last;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [BW-1:0]           r_bit_cnt;
  logic [BW-1:0]           r_msb;
  logic [BW-1:0]           w_msb;
  logic signed [PW-1:0]    w_p   [LANES];
  logic signed [ACC_W-1:0] w_acc [LANES];
  logic [LANES-1:0]        w_sat;
  assign w_msb = bus.prec == 2'b01 ? BW'(WGT_W/2 - 1) :
                 bus.prec == 2'b10 ? BW'(WGT_W/4 - 1) : BW'(WGT_W - 1);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PW-1:0] w_term;
    logic signed [PW-1:0] w_add;
    assign w_term = $signed({{WGT_W{r_act[i][ACT_W-1]}}, r_act[i]}) <<< r_msb;
    // the weight sign bit carries negative significance, so it subtracts
    assign w_add  = !r_wgt[i][r_bit_cnt] ? '0 : (r_bit_cnt == r_msb ? -w_term : w_term);
    assign w_p[i] = (r_p[i] >>> 1) + w_add;
`ifdef BITSERIAL_SAT_EN
    logic signed [ACC_W:0] w_sum;
    assign w_sum    = (ACC_W+1)'(r_acc[i]) + (ACC_W+1)'(w_p[i]);
    assign w_sat[i] = w_sum[ACC_W] != w_sum[ACC_W-1];
    assign w_acc[i] = w_sat[i] ? {w_sum[ACC_W], {(ACC_W-1){~w_sum[ACC_W]}}} : w_sum[ACC_W-1:0];
`else
    assign w_sat[i] = 1'b0;
    assign w_acc[i] = r_acc[i] + ACC_W'(w_p[i]);
`endif
  end
  always_comb begin
    bus.out_acc = '0;
    for (int k = 0; k < LANES; k++) bus.out_acc[k*ACC_W +: ACC_W] = r_acc[k];
  end
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.bit_cnt   = r_bit_cnt;
  assign bus.ovf       = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bit_cnt   <= '0;
      r_msb       <= '0;
      r_last      <= 1'b0;
      r_ovf       <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_act[k] <= '0;
        r_wgt[k] <= '0;
        r_p[k]   <= '0;
        r_acc[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.acc_clr) begin
            r_ovf <= '0;
            for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
          end
          if (bus.in_valid) begin
            for (int k = 0; k < LANES; k++) begin
              r_act[k] <= bus.act[k*ACT_W +: ACT_W];
              r_wgt[k] <= bus.wgt[k*WGT_W +: WGT_W];
              r_p[k]   <= '0;
            end
            r_msb      <= w_msb;
            r_last     <= bus.in_last;
            r_bit_cnt  <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < LANES; k++) r_p[k] <= w_p[k];
          r_bit_cnt <= r_bit_cnt + BW'(1);
          if (r_bit_cnt == r_msb) begin
            for (int k = 0; k < LANES; k++) r_acc[k] <= w_acc[k];
            r_ovf       <= r_ovf | w_sat;
            r_bit_cnt   <= '0;
            r_in_ready  <= !r_last;
            r_out_valid <= r_last;
            r_state     <= r_last ? OUT : IDLE;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            r_ovf       <= '0;
            for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitserial_mac_lanes.sv
// tb_bitserial_mac_lanes: random and directed ops on a 20-bit and a 16-bit accumulator instance in lockstep,
// checked against an arithmetic dot-product model.
module tb_bitserial_mac_lanes;
  localparam int L = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  longint m20 [L];
  longint m16 [L];
  logic [L-1:0] o20, o16;
  always #5 clk = ~clk;
  bitserial_mac_lanes_if #(.LANES(L), .ACT_W(8), .WGT_W(8), .ACC_W(20)) b20 ();
  bitserial_mac_lanes_if #(.LANES(L), .ACT_W(8), .WGT_W(8), .ACC_W(16)) b16 ();
  bitserial_mac_lanes #(.LANES(L), .ACT_W(8), .WGT_W(8), .ACC_W(20)) dut   (.clk(clk), .rst(rst), .bus(b20.slave));
  bitserial_mac_lanes #(.LANES(L), .ACT_W(8), .WGT_W(8), .ACC_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
  assign b16.prec      = b20.prec;
  assign b16.in_valid  = b20.in_valid;
  assign b16.in_last   = b20.in_last;
  assign b16.acc_clr   = b20.acc_clr;
  assign b16.act       = b20.act;
  assign b16.wgt       = b20.wgt;
  assign b16.out_ready = b20.out_ready;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int nb_of(input logic [1:0] pr);
    return pr == 2'b01 ? 4 : pr == 2'b10 ? 2 : 8;
  endfunction
  function automatic longint prod(input logic [7:0] a, input logic [7:0] w, input int nb);
    longint wv = longint'(w) & ((longint'(1) << nb) - 1);
    if (wv >= (longint'(1) << (nb - 1))) wv = wv - (longint'(1) << nb);
    return longint'($signed(a)) * wv;
  endfunction
  function automatic logic [31:0] l0(input logic [7:0] v);
    return {24'($urandom), v};
  endfunction
  task automatic acc_add(inout longint a, input longint p, input int w, inout logic o);
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint s = a + p;
`ifdef BITSERIAL_SAT_EN
    if (s > hi) begin s = hi; o = 1'b1; end
    else if (s < -hi - 1) begin s = -hi - 1; o = 1'b1; end
`else
    s = s & (2 * hi + 1);
    if (s > hi) s = s - 2 * (hi + 1);
`endif
    a = s;
  endtask
  task automatic model_clr();
    for (int k = 0; k < L; k++) begin m20[k] = 0; m16[k] = 0; end
    o20 = '0;
    o16 = '0;
  endtask
  task automatic check_out(input string tag);
    logic [L*20-1:0] e20;
    logic [L*16-1:0] e16;
    for (int k = 0; k < L; k++) begin
      e20[k*20 +: 20] = 20'(m20[k]);
      e16[k*16 +: 16] = 16'(m16[k]);
    end
    chk({tag, "_acc20"}, b20.out_acc, e20);
    chk({tag, "_acc16"}, b16.out_acc, e16);
    chk({tag, "_ovf20"}, b20.ovf, o20);
    chk({tag, "_ovf16"}, b16.ovf, o16);
  endtask
  task automatic op(input logic [1:0] pr, input logic [31:0] a, input logic [31:0] w, input logic last, input logic clr);
    int nb = nb_of(pr);
    int n = 0;
    chk("idle_in_ready", b20.in_ready, 1);
    b20.prec = pr; b20.act = a; b20.wgt = w; b20.in_last = last; b20.acc_clr = clr; b20.in_valid = 1'b1;
    @(posedge clk); #1;
    b20.in_valid = 1'b0;
    b20.prec = 2'($urandom); b20.act = $urandom; b20.wgt = $urandom;
    b20.acc_clr = 1'($urandom); b20.in_last = 1'($urandom);
    if (clr) model_clr();
    for (int k = 0; k < L; k++) begin
      longint p = prod(a[k*8 +: 8], w[k*8 +: 8], nb);
      acc_add(m20[k], p, 20, o20[k]);
      acc_add(m16[k], p, 16, o16[k]);
    end
    chk("run_in_ready", b20.in_ready, 0);
    while (!(last ? b20.out_valid : b20.in_ready) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    b20.acc_clr = 1'b0;
    chk("latency", n, nb);
    if (last) check_out("result");
  endtask
  task automatic drain(input int hold);
    for (int c = 0; c < hold; c++) begin
      b20.acc_clr = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", b20.out_valid, 1);
      chk("bp_in_ready", b20.in_ready, 0);
      check_out("bp");
    end
    b20.acc_clr = 1'b0;
    b20.out_ready = 1'b1;
    @(posedge clk); #1;
    b20.out_ready = 1'b0;
    model_clr();
    chk("drain_out_valid", b20.out_valid, 0);
    chk("drain_in_ready", b20.in_ready, 1);
    check_out("drain");
  endtask
  initial begin
    int n;
    b20.prec = '0; b20.in_valid = 1'b0; b20.in_last = 1'b0; b20.acc_clr = 1'b0;
    b20.act = '0; b20.wgt = '0; b20.out_ready = 1'b0;
    model_clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", b20.in_ready, 1);
    chk("rst_out_valid", b20.out_valid, 0);
    chk("rst_bit_cnt", b20.bit_cnt, 0);
    check_out("rst");
    rst = 1'b0;
    op(2'b00, l0(8'h67), l0(8'h0A), 1'b0, 1'b1);
    op(2'b00, l0(8'h3F), l0(8'hE1), 1'b1, 1'b0);
    chk("t1_lane0", b20.out_acc[19:0], 20'hFFC65);
    drain(0);
    op(2'b00, l0(8'h80), l0(8'h80), 1'b1, 1'b0);
    chk("t2_lane0", b20.out_acc[19:0], 20'h04000);
    drain(0);
    op(2'b01, l0(8'h7B), l0(8'h48), 1'b1, 1'b0);
    chk("t3a_lane0", b20.out_acc[19:0], 20'hFFC28);
    drain(0);
    op(2'b10, l0(8'h5C), l0(8'h4E), 1'b1, 1'b0);
    chk("t3b_lane0", b20.out_acc[19:0], 20'hFFF48);
    drain(10);
    op(2'b00, $urandom, $urandom, 1'b0, 1'b0);
    op(2'b00, l0(8'h05), l0(8'h03), 1'b1, 1'b1);
    chk("t4_clr_lane0", b20.out_acc[19:0], 20'd15);
    drain(2);
    b20.prec = 2'b00; b20.act = $urandom; b20.wgt = $urandom; b20.in_last = 1'b1; b20.in_valid = 1'b1;
    @(posedge clk); #1;
    b20.in_valid = 1'b0;
    n = 0;
    while (b20.bit_cnt != 3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_bit_cnt", b20.bit_cnt, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clr();
    chk("t5_in_ready", b20.in_ready, 1);
    chk("t5_out_valid", b20.out_valid, 0);
    chk("t5_bit_cnt0", b20.bit_cnt, 0);
    check_out("t5_rst");
    op(2'b00, l0(8'h12), l0(8'h03), 1'b1, 1'b0);
    chk("t5_clean", b20.out_acc[19:0], 20'd54);
    drain(0);
    op(2'b00, l0(8'h80), l0(8'h80), 1'b0, 1'b1);
    op(2'b00, l0(8'h80), l0(8'h80), 1'b1, 1'b0);
`ifdef BITSERIAL_SAT_EN
    chk("t6_acc16", b16.out_acc[15:0], 16'h7FFF);
    chk("t6_ovf16", b16.ovf[0], 1'b1);
`else
    chk("t6_acc16", b16.out_acc[15:0], 16'h8000);
    chk("t6_ovf16", b16.ovf, 4'h0);
`endif
    drain(0);
    for (int t = 0; t < 40; t++) begin
      logic last;
      last = ($urandom % 3) == 0;
      op(2'($urandom), $urandom, $urandom, last, ($urandom % 4) == 0);
      if (last) drain($urandom % 3);
    end
    op(2'($urandom), $urandom, $urandom, 1'b1, 1'b0);
    drain(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
